// File: rtl/fp32_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pipelined_adder
// Description : Fully pipelined IEEE-754 binary32 adder, round-to-nearest-even,
//               fixed latency of PIPELINE_DEPTH-1 clock edges.
// Revision    : 1.0
// ============================================================================
module fp32_pipelined_adder #(
    parameter int PIPELINE_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    output logic [31:0] result
);

    localparam int c_NUM_STAGES = PIPELINE_DEPTH - 1;
    // Stage word: {nan, inf, sign, exponent[7:0], sum[27:0]}
    localparam int c_PW = 39;

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
    logic [31:0] w_big, w_small;
    logic [7:0]  w_big_exp, w_small_exp, w_exp_diff;
    logic [23:0] w_big_man, w_small_man;
    logic [49:0] w_small_wide;
    logic [26:0] w_small_aligned;
    logic [27:0] w_sum;
    logic        w_nan, w_inf, w_sign;
    logic [c_PW-1:0] w_stage_d;

    // Front half: unpack, swap, align, add/subtract.
    always_comb begin
        w_a_nan     = (lhs[30:23] == 8'hFF) && (lhs[22:0] != 23'd0);
        w_b_nan     = (rhs[30:23] == 8'hFF) && (rhs[22:0] != 23'd0);
        w_a_inf     = (lhs[30:23] == 8'hFF) && (lhs[22:0] == 23'd0);
        w_b_inf     = (rhs[30:23] == 8'hFF) && (rhs[22:0] == 23'd0);
        w_swap      = rhs[30:0] > lhs[30:0];
        w_big       = w_swap ? rhs : lhs;
        w_small     = w_swap ? lhs : rhs;
        w_big_exp   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_small_exp = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_big_man   = {(w_big[30:23] != 8'd0), w_big[22:0]};
        w_small_man = {(w_small[30:23] != 8'd0), w_small[22:0]};
        w_exp_diff  = w_big_exp - w_small_exp;

        // Aligned operand: 24 significand bits, guard, round, sticky.
        w_small_wide = {w_small_man, 26'd0} >> w_exp_diff;
        if (w_exp_diff >= 8'd26) begin
            w_small_aligned = {26'd0, |w_small_man};
        end else begin
            w_small_aligned = {w_small_wide[49:24], |w_small_wide[23:0]};
        end

        if (w_big[31] ^ w_small[31]) begin
            w_sum = {1'b0, w_big_man, 3'd0} - {1'b0, w_small_aligned};
        end else begin
            w_sum = {1'b0, w_big_man, 3'd0} + {1'b0, w_small_aligned};
        end

        w_nan = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (lhs[31] ^ rhs[31]));
        w_inf = w_a_inf | w_b_inf;
        // A zero sum is -0 only when both operands are negative.
        if (w_inf) begin
            w_sign = w_a_inf ? lhs[31] : rhs[31];
        end else if (w_sum == 28'd0) begin
            w_sign = lhs[31] & rhs[31];
        end else begin
            w_sign = w_big[31];
        end
        w_stage_d = {w_nan, w_inf, w_sign, w_big_exp, w_sum};
    end

    logic [c_PW-1:0] w_pipe_d [c_NUM_STAGES];
    logic [c_PW-1:0] r_pipe_q [c_NUM_STAGES];

    always_comb begin
        w_pipe_d[0] = w_stage_d;
        for (int i = 1; i < c_NUM_STAGES; i++) begin
            w_pipe_d[i] = r_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_STAGES; i++) begin
                r_pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_NUM_STAGES; i++) begin
                r_pipe_q[i] <= w_pipe_d[i];
            end
        end
    end

    logic        w_out_nan, w_out_inf, w_out_sign;
    logic [9:0]  w_out_exp, w_shift_limit, w_norm_exp, w_final_exp;
    logic [27:0] w_out_sum;
    logic [4:0]  w_lzc, w_shift;
    logic [26:0] w_norm_man;
    logic        w_round_up;
    logic [24:0] w_rounded;
    logic [22:0] w_frac;

    // Back half: normalize, round, pack.
    always_comb begin
        w_out_nan  = r_pipe_q[c_NUM_STAGES-1][38];
        w_out_inf  = r_pipe_q[c_NUM_STAGES-1][37];
        w_out_sign = r_pipe_q[c_NUM_STAGES-1][36];
        w_out_exp  = {2'b00, r_pipe_q[c_NUM_STAGES-1][35:28]};
        w_out_sum  = r_pipe_q[c_NUM_STAGES-1][27:0];

        w_lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_out_sum[i]) begin
                w_lzc = 5'(26 - i);
            end
        end

        // Left shift stops at exponent 1 so tiny results land as subnormals.
        w_shift_limit = w_out_exp - 10'd1;
        w_shift       = 5'd0;
        if (w_out_sum[27]) begin
            w_norm_man = {w_out_sum[27:2], w_out_sum[1] | w_out_sum[0]};
            w_norm_exp = w_out_exp + 10'd1;
        end else begin
            w_shift    = ({5'd0, w_lzc} < w_shift_limit) ? w_lzc : w_shift_limit[4:0];
            w_norm_man = w_out_sum[26:0] << w_shift;
            w_norm_exp = w_out_exp - {5'd0, w_shift};
        end

        w_round_up = w_norm_man[2] & (w_norm_man[3] | w_norm_man[1] | w_norm_man[0]);
        w_rounded  = {1'b0, w_norm_man[26:3]} + {24'd0, w_round_up};
        if (w_rounded[24]) begin
            w_final_exp = w_norm_exp + 10'd1;
            w_frac      = w_rounded[23:1];
        end else begin
            w_final_exp = w_rounded[23] ? w_norm_exp : 10'd0;
            w_frac      = w_rounded[22:0];
        end

        if (w_out_nan) begin
            result = 32'h7FC0_0000;
        end else if (w_out_inf) begin
            result = {w_out_sign, 8'hFF, 23'd0};
        end else if (w_out_sum == 28'd0) begin
            result = {w_out_sign, 31'd0};
        end else if (w_final_exp >= 10'd255) begin
            result = {w_out_sign, 8'hFF, 23'd0};
        end else begin
            result = {w_out_sign, w_final_exp[7:0], w_frac};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_pipelined_adder
// Description : Scoreboard bench for fp32_pipelined_adder against an exact
//               wide-integer binary32 RNE reference.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fp32_pipelined_adder;

    localparam int DEPTH = 3;
    localparam int LAT   = DEPTH - 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lhs = '0;
    logic [31:0] rhs = '0;
    logic [31:0] result;
    logic        issue_flag = 1'b0;
    logic [LAT-1:0] vpipe = '0;
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    fp32_pipelined_adder #(.PIPELINE_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .lhs    (lhs),
        .rhs    (rhs),
        .result (result)
    );

    // Operand value as an integer count of 2^-149 units.
    function automatic logic [289:0] to_int(input logic [31:0] x);
        logic [289:0] r;
        int ee;
        r = '0;
        r[23:0] = {(x[30:23] != 8'd0), x[22:0]};
        ee = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        return r << (ee - 1);
    endfunction

    function automatic logic [30:0] round_mag(input logic [289:0] mag);
        int p, sh;
        logic [289:0] q, rem, half;
        logic [9:0] ef;
        p = 0;
        for (int i = 0; i < 290; i++) if (mag[i]) p = i;
        if (p <= 23) return mag[30:0];
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 290'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 290'd1;
        if (q[24]) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        ef = 10'(sh + 1);
        if (ef >= 10'd255) return 31'h7F80_0000;
        return {ef[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf, sr;
        logic [289:0] ma, mb, mag;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:0] == 31'h7F80_0000);
        b_inf = (b[30:0] == 31'h7F80_0000);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (a_inf) return a;
        if (b_inf) return b;
        ma = to_int(a);
        mb = to_int(b);
        if (a[31] == b[31]) begin
            mag = ma + mb; sr = a[31];
        end else if (ma >= mb) begin
            mag = ma - mb; sr = a[31];
        end else begin
            mag = mb - ma; sr = b[31];
        end
        if (mag == 0) return {a[31] & b[31], 31'd0};
        return {sr, round_mag(mag)};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: r[30:23] = 8'd0;
            2: r[30:0]  = 31'd0;
            3: r[30:0]  = 31'h7F80_0000;
            4: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            5: r[30:23] = 8'(248 + $urandom_range(0, 6));
            default: r[30:23] = 8'(120 + $urandom_range(0, 14));
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s lhs=%08h rhs=%08h got=%08h expected=%08h", name, a, b, act, expv);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        exp_t t;
        lhs = a;
        rhs = b;
        issue_flag = 1'b1;
        t.a = a; t.b = b; t.e = ref_add(a, b);
        exp_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic random_ops(input int n);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = rand_fp();
            case ($urandom_range(0, 3))
                0: b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 15))};
                1: b = {1'($urandom), 8'(a[30:23] - 8'($urandom_range(0, 30))), 23'($urandom)};
                default: b = rand_fp();
            endcase
            issue(a, b);
        end
    endtask

    // Tracks which output cycles carry an issued operation.
    always @(posedge clk) begin
        if (rst) begin
            vpipe = '0;
            exp_q.delete();
        end else begin
            vpipe = (vpipe << 1) | LAT'(issue_flag);
        end
    end

    always @(negedge clk) begin
        exp_t t;
        if (rst) begin
            check("reset_zero", lhs, rhs, result, 32'h0);
        end else if (vpipe[LAT-1]) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_empty got=%08h expected=queued result", result);
            end else begin
                t = exp_q.pop_front();
                check("sum", t.a, t.b, result, t.e);
            end
        end else begin
            check("idle_zero", lhs, rhs, result, 32'h0);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(32'h3F80_0000, 32'h4000_0000);
        repeat (4) issue(32'h0, 32'h0);

        issue(32'h3F80_0000, 32'hBF80_0000);
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF);
        issue(32'h0000_0001, 32'h0000_0001);

        issue(32'h3F80_0000, 32'h3380_0000);
        issue(32'h3F80_0001, 32'h3380_0000);
        issue(32'h3F80_0000, 32'h3380_0001);
        issue(32'h7F80_0000, 32'hFF80_0000);
        issue(32'h7F80_0001, 32'h3F80_0000);
        issue(32'h8000_0000, 32'h8000_0000);
        issue(32'h0000_0000, 32'h8000_0000);
        issue(32'hFF80_0000, 32'h42C8_0000);
        issue(32'h0080_0000, 32'h8000_0001);
        issue(32'h3F80_0001, 32'hBF80_0000);
        issue(32'h8000_0005, 32'h0000_0000);
        issue(32'hFF7F_FFFF, 32'hF380_0000);

        random_ops(600);

        // Mid-stream reset with operations in flight.
        issue(32'h3F80_0000, 32'h3F80_0000);
        issue(32'h4000_0000, 32'h4000_0000);
        issue(32'h4040_0000, 32'h4040_0000);
        rst = 1'b1;
        issue_flag = 1'b0;
        lhs = $urandom;
        rhs = $urandom;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        issue(32'h4000_0000, 32'h4040_0000);
        repeat (LAT + 1) issue(32'h0, 32'h0);

        random_ops(300);
        repeat (LAT + 1) issue(32'h0, 32'h0);
        issue_flag = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
